// File: rtl/exc_pkg.sv
// Shared definitions for the trap sequencer: FSM encoding, cause codes and the
// default handler entry point.
package exc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FLUSH    = 3'd1,
    ST_REDIRECT = 3'd2,
    ST_HANDLER  = 3'd3,
    ST_RETURN   = 3'd4,
    ST_HALT     = 3'd5
  } exc_state_e;

  localparam logic [3:0] EXC_NONE   = 4'd0;
  localparam logic [3:0] EXC_REG    = 4'd1;
  localparam logic [3:0] EXC_PC     = 4'd2;
  localparam logic [3:0] EXC_OVF    = 4'd3;
  localparam logic [3:0] EXC_MIS_LD = 4'd4;
  localparam logic [3:0] EXC_MIS_ST = 4'd5;
  localparam logic [3:0] EXC_DIVZ   = 4'd6;

  localparam logic [31:0] HANDLER_ADDR_DEF = 32'h0000_0080;

endpackage

// File: rtl/exc_prio_enc.sv
// Combinational priority encoder: raw fault sources -> any-fault flag + cause.
// Does not look at the gating stage's enable; callers qualify it themselves.
module exc_prio_enc
  import exc_pkg::*;
(
  input  logic       pc_exception,
  input  logic       reg_error,
  input  logic [7:0] alu_status,
  input  logic [1:0] mem_sig,
  output logic       fault,
  output logic [3:0] code
);

  logic ovf, mis, divz;
  logic unused_alu;

  assign ovf  = alu_status[6];
  assign mis  = alu_status[3];
  assign divz = alu_status[2];
  assign unused_alu = ^{alu_status[7], alu_status[5:4], alu_status[1:0]};

  // Highest-priority source wins; a store outranks a load on misalignment.
  always_comb begin
    code = EXC_NONE;
    if (reg_error)             code = EXC_REG;
    else if (pc_exception)     code = EXC_PC;
    else if (ovf)              code = EXC_OVF;
    else if (mis & mem_sig[1]) code = EXC_MIS_ST;
    else if (mis & mem_sig[0]) code = EXC_MIS_LD;
    else if (divz)             code = EXC_DIVZ;
  end

  assign fault = (code != EXC_NONE);

endmodule

// File: rtl/exception_ctrl.sv
// Trap sequencer: records cause/PC of a suppressed instruction, flushes, redirects
// fetch to the handler, returns on eret, halts on a double fault.
// Optional: define EXC_COUNT_EN to add a saturating 16-bit trap counter (exc_count).
module exception_ctrl
  import exc_pkg::*;
#(
  parameter int              PC_W         = 32,
  parameter logic [PC_W-1:0] HANDLER_ADDR = PC_W'(HANDLER_ADDR_DEF)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            pc_exception,
  input  logic            reg_error,
  input  logic [7:0]      alu_status,
  input  logic [1:0]      mem_sig,
  input  logic            enable,
  input  logic [PC_W-1:0] pc_current,
  input  logic            eret,
  input  logic            redirect_ready,
  output logic            redirect_valid,
  output logic [PC_W-1:0] redirect_pc,
  output logic            flush,
  output logic            stall,
  output logic            exl,
  output logic [PC_W-1:0] epc,
  output logic [3:0]      cause,
  output logic            double_fault
`ifdef EXC_COUNT_EN
  , output logic [15:0]   exc_count
`endif
);

  exc_state_e state, state_nxt;
  logic       src_fault, fault;
  logic [3:0] code;

  exc_prio_enc u_enc (
    .pc_exception (pc_exception),
    .reg_error    (reg_error),
    .alu_status   (alu_status),
    .mem_sig      (mem_sig),
    .fault        (src_fault),
    .code         (code)
  );

  // enable=0 with no source set is an inconsistent input and not a fault.
  assign fault = !enable && src_fault;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic and state-decoded outputs.
  always_comb begin
    state_nxt      = state;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    flush          = 1'b0;
    stall          = 1'b0;
    unique case (state)
      ST_IDLE: if (fault) state_nxt = ST_FLUSH;
      ST_FLUSH: begin
        flush     = 1'b1;
        stall     = 1'b1;
        state_nxt = ST_REDIRECT;
      end
      ST_REDIRECT: begin
        stall          = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = HANDLER_ADDR;
        if (redirect_ready) state_nxt = ST_HANDLER;
      end
      // Fault beats eret in the same cycle.
      ST_HANDLER: begin
        if (fault)     state_nxt = ST_HALT;
        else if (eret) state_nxt = ST_RETURN;
      end
      ST_RETURN: begin
        stall          = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = epc;
        if (redirect_ready) state_nxt = ST_IDLE;
      end
      ST_HALT: stall = 1'b1;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Architectural trap state: epc/cause on entry, exl across the handler,
  // sticky double fault. epc survives the return.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      epc          <= '0;
      cause        <= EXC_NONE;
      exl          <= 1'b0;
      double_fault <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: if (fault) begin
          epc   <= pc_current;
          cause <= code;
        end
        ST_FLUSH:   exl <= 1'b1;
        ST_HANDLER: if (fault) double_fault <= 1'b1;
        ST_RETURN: if (redirect_ready) begin
          exl   <= 1'b0;
          cause <= EXC_NONE;
        end
        default: ;
      endcase
    end
  end

`ifdef EXC_COUNT_EN
  logic [15:0] cnt_q;

  // Counts trap entries from IDLE only; saturates instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                        cnt_q <= '0;
    else if (state == ST_IDLE && fault && cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
  end

  assign exc_count = cnt_q;
`endif

endmodule

// File: tb/tb_exception_ctrl.sv
// Directed bench for exception_ctrl. Inputs change 1ns after the rising edge and
// outputs are checked there, i.e. they show the state entered on that edge.
module tb_exception_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pc_exception = 1'b0;
  logic        reg_error = 1'b0;
  logic [7:0]  alu_status = '0;
  logic [1:0]  mem_sig = '0;
  logic        enable = 1'b1;
  logic [31:0] pc_current = '0;
  logic        eret = 1'b0;
  logic        redirect_ready = 1'b0;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        flush, stall, exl, double_fault;
  logic [31:0] epc;
  logic [3:0]  cause;
`ifdef EXC_COUNT_EN
  logic [15:0] exc_count;
`endif

  int total = 0;
  int bad = 0;

  exception_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pc_exception   (pc_exception),
    .reg_error      (reg_error),
    .alu_status     (alu_status),
    .mem_sig        (mem_sig),
    .enable         (enable),
    .pc_current     (pc_current),
    .eret           (eret),
    .redirect_ready (redirect_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .flush          (flush),
    .stall          (stall),
    .exl            (exl),
    .epc            (epc),
    .cause          (cause),
    .double_fault   (double_fault)
`ifdef EXC_COUNT_EN
    , .exc_count    (exc_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    pc_exception = 1'b0; reg_error = 1'b0; alu_status = '0; mem_sig = '0;
    enable = 1'b1; eret = 1'b0; redirect_ready = 1'b0;
  endtask

  // From FLUSH: one cycle to REDIRECT, accept, then eret and accept the return.
  task automatic finish_trap;
    clear_inputs();
    tick();                                  // REDIRECT
    redirect_ready = 1'b1; tick();           // HANDLER
    redirect_ready = 1'b0; eret = 1'b1; tick(); // RETURN
    eret = 1'b0; redirect_ready = 1'b1; tick(); // IDLE
    redirect_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #12;
    total++; if ({redirect_valid, flush, stall, exl, double_fault} !== 5'b0) begin
      bad++; $display("FAIL reset_flags got=%b exp=00000", {redirect_valid, flush, stall, exl, double_fault});
    end
    total++; if (epc !== 32'h0 || cause !== 4'h0 || redirect_pc !== 32'h0) begin
      bad++; $display("FAIL reset_regs epc=%h cause=%0d rpc=%h exp=0", epc, cause, redirect_pc);
    end
    @(negedge clk); rst_n = 1'b1;
    tick();
    total++; if (redirect_valid !== 1'b0) begin
      bad++; $display("FAIL reset_no_pending got=%b exp=0", redirect_valid);
    end
  endtask

  task automatic test_overflow_handshake;
    alu_status = 8'h40; enable = 1'b0; pc_current = 32'h0000_1004;
    tick();                                  // N+1: FLUSH
    total++; if (flush !== 1'b1 || cause !== 4'd3 || epc !== 32'h1004 || stall !== 1'b1 || exl !== 1'b0) begin
      bad++; $display("FAIL ovf_n1 flush=%b cause=%0d epc=%h stall=%b exl=%b exp=1 3 1004 1 0", flush, cause, epc, stall, exl);
    end
    clear_inputs();
    tick();                                  // N+2: REDIRECT
    total++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h80 || exl !== 1'b1 || flush !== 1'b0) begin
      bad++; $display("FAIL ovf_n2 v=%b pc=%h exl=%b flush=%b exp=1 80 1 0", redirect_valid, redirect_pc, exl, flush);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      total++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h80 || stall !== 1'b1) begin
        bad++; $display("FAIL hs_hold%0d v=%b pc=%h stall=%b exp=1 80 1", i, redirect_valid, redirect_pc, stall);
      end
    end
    redirect_ready = 1'b1; tick();           // HANDLER
    redirect_ready = 1'b0;
    total++; if (stall !== 1'b0 || exl !== 1'b1 || redirect_valid !== 1'b0) begin
      bad++; $display("FAIL hs_handler stall=%b exl=%b v=%b exp=0 1 0", stall, exl, redirect_valid);
    end
  endtask

  task automatic test_return;
    eret = 1'b1; tick();                     // RETURN
    eret = 1'b0;
    total++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h1004 || stall !== 1'b1) begin
      bad++; $display("FAIL ret_req v=%b pc=%h stall=%b exp=1 1004 1", redirect_valid, redirect_pc, stall);
    end
    redirect_ready = 1'b1; tick();           // IDLE
    redirect_ready = 1'b0;
    total++; if (exl !== 1'b0 || cause !== 4'd0 || redirect_valid !== 1'b0 || stall !== 1'b0 || epc !== 32'h1004) begin
      bad++; $display("FAIL ret_done exl=%b cause=%0d v=%b stall=%b epc=%h exp=0 0 0 0 1004", exl, cause, redirect_valid, stall, epc);
    end
  endtask

  task automatic test_priority;
    reg_error = 1'b1; alu_status = 8'h44; enable = 1'b0; pc_current = 32'h2000;
    tick();
    total++; if (cause !== 4'd1 || epc !== 32'h2000) begin
      bad++; $display("FAIL prio_reg cause=%0d epc=%h exp=1 2000", cause, epc);
    end
    finish_trap();
    alu_status = 8'h08; mem_sig = 2'b10; enable = 1'b0; pc_current = 32'h2010;
    tick();
    total++; if (cause !== 4'd5) begin
      bad++; $display("FAIL prio_mis_st cause=%0d exp=5", cause);
    end
    finish_trap();
    alu_status = 8'h0C; mem_sig = 2'b01; enable = 1'b0;
    tick();
    total++; if (cause !== 4'd4) begin
      bad++; $display("FAIL prio_mis_ld cause=%0d exp=4", cause);
    end
    finish_trap();
    // ready already high when the redirect appears: HANDLER one cycle later
    alu_status = 8'h04; enable = 1'b0; redirect_ready = 1'b1;
    tick();                                  // FLUSH
    total++; if (cause !== 4'd6) begin
      bad++; $display("FAIL prio_divz cause=%0d exp=6", cause);
    end
    alu_status = '0; enable = 1'b1;
    tick();                                  // REDIRECT
    tick();                                  // HANDLER
    total++; if (stall !== 1'b0 || exl !== 1'b1 || redirect_valid !== 1'b0) begin
      bad++; $display("FAIL ready_early stall=%b exl=%b v=%b exp=0 1 0", stall, exl, redirect_valid);
    end
    redirect_ready = 1'b0; eret = 1'b1; tick();
    eret = 1'b0; redirect_ready = 1'b1; tick();
    redirect_ready = 1'b0;
  endtask

  task automatic test_no_fault;
    reg_error = 1'b1; enable = 1'b1; tick();              // gated off
    total++; if (flush !== 1'b0 || cause !== 4'd0) begin
      bad++; $display("FAIL nf_enabled flush=%b cause=%0d exp=0 0", flush, cause);
    end
    clear_inputs(); enable = 1'b0; tick();                // inconsistent
    total++; if (flush !== 1'b0) begin
      bad++; $display("FAIL nf_nosrc flush=%b exp=0", flush);
    end
    alu_status = 8'hBB; mem_sig = 2'b00; tick();          // ignored bits, misalign w/o access
    total++; if (flush !== 1'b0 || stall !== 1'b0) begin
      bad++; $display("FAIL nf_ignored flush=%b stall=%b exp=0 0", flush, stall);
    end
    clear_inputs(); eret = 1'b1; tick();                  // eret in IDLE
    eret = 1'b0;
    total++; if (redirect_valid !== 1'b0 || stall !== 1'b0) begin
      bad++; $display("FAIL nf_eret_idle v=%b stall=%b exp=0 0", redirect_valid, stall);
    end
  endtask

  task automatic test_double_fault;
    pc_exception = 1'b1; enable = 1'b0; pc_current = 32'h3000;
    tick();
    clear_inputs(); tick();
    redirect_ready = 1'b1; tick();           // HANDLER
    redirect_ready = 1'b0;
    eret = 1'b1; pc_exception = 1'b1; enable = 1'b0; pc_current = 32'h4444;
    tick();
    clear_inputs();
    total++; if (double_fault !== 1'b1 || stall !== 1'b1 || epc !== 32'h3000 || cause !== 4'd2 || redirect_valid !== 1'b0) begin
      bad++; $display("FAIL dfault df=%b stall=%b epc=%h cause=%0d v=%b exp=1 1 3000 2 0", double_fault, stall, epc, cause, redirect_valid);
    end
    redirect_ready = 1'b1; eret = 1'b1;
    tick(); tick(); tick();
    clear_inputs();
    total++; if (double_fault !== 1'b1 || stall !== 1'b1 || redirect_valid !== 1'b0) begin
      bad++; $display("FAIL dfault_stuck df=%b stall=%b v=%b exp=1 1 0", double_fault, stall, redirect_valid);
    end
    #2 rst_n = 1'b0; #1;                     // asynchronous, mid-cycle
    total++; if ({double_fault, stall, exl, flush, redirect_valid} !== 5'b0 || epc !== 32'h0 || cause !== 4'h0) begin
      bad++; $display("FAIL dfault_reset flags=%b epc=%h cause=%0d exp=0", {double_fault, stall, exl, flush, redirect_valid}, epc, cause);
    end
    @(negedge clk); rst_n = 1'b1;
    tick();
  endtask

`ifdef EXC_COUNT_EN
  task automatic test_count;
    for (int i = 0; i < 3; i++) begin
      reg_error = 1'b1; enable = 1'b0; tick();
      finish_trap();
    end
    total++; if (exc_count !== 16'd3) begin
      bad++; $display("FAIL count3 got=%0d exp=3", exc_count);
    end
    force dut.cnt_q = 16'hFFFF;
    #1 release dut.cnt_q;
    reg_error = 1'b1; enable = 1'b0; tick();
    finish_trap();
    total++; if (exc_count !== 16'hFFFF) begin
      bad++; $display("FAIL count_sat got=%h exp=ffff", exc_count);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_overflow_handshake();
    test_return();
    test_priority();
    test_no_fault();
    test_double_fault();
`ifdef EXC_COUNT_EN
    test_count();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #20000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
